mem_stage: RTL

Memory-access pipeline stage between the execute stage and the write-back stage. It accepts one instruction per handshake from EXE and waits for the load data response on the SRAM-like data bus. It extracts, sign/zero-extends or merges (lwl/lwr) the returned word and forwards the result to WB. On a write-back flush it drops the in-flight instruction and discards data responses for loads that are already outstanding.

---
 rtl/mem_stage_if.sv | 28 ++
 rtl/mem_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: EXE -> MEM handshake and payload bundle.
//   master (EXE side): drives es_to_ms_valid and the es_* payload, samples ms_allowin
//   slave  (MEM side): samples es_to_ms_valid and the es_* payload, drives ms_allowin
interface mem_stage_if;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic [31:0] es_rt_value;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_load;
    logic        es_mem_req;
    logic [3:0]  es_mem_num;
    logic        es_sign_ext;
    logic        es_lwl;
    logic        es_lwr;
    modport master (
        output es_to_ms_valid, es_pc, es_result, es_rt_value, es_dest, es_gr_we,
               es_load, es_mem_req, es_mem_num, es_sign_ext, es_lwl, es_lwr,
        input  ms_allowin
    );
    modport slave (
        input  es_to_ms_valid, es_pc, es_result, es_rt_value, es_dest, es_gr_we,
               es_load, es_mem_req, es_mem_num, es_sign_ext, es_lwl, es_lwr,
        output ms_allowin
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EXE and WB.
//   clk, reset        : clock, synchronous active-high reset
//   es                : EXE -> MEM handshake/payload (mem_stage_if.slave)
//   data_data_ok/rdata: load data response from the SRAM-like bus
//   ws_allowin        : WB can accept; ws_reflush: exception/eret flush from WB
//   ms_to_ws_valid, ms_pc, ms_result, ms_dest, ms_gr_we: result to WB
//   ms_fwd_valid      : valid register write, for DS bypass
//   ms_load_pending   : load data not yet available, DS must stall on a match
// Build option: define MS_LWLR_EN to enable the lwl/lwr merge logic; without it
// lwl/lwr loads return the full aligned word.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  es,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        ws_allowin,
    input  logic        ws_reflush,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_result,
    output logic [4:0]  ms_dest,
    output logic        ms_gr_we,
    output logic        ms_fwd_valid,
    output logic        ms_load_pending
);
    typedef enum logic [1:0] {EMPTY, WAIT, HELD, READY} state_t;
    state_t      state;
    logic [1:0]  discard_cnt;
    logic [31:0] res_r;
    logic [31:0] buf_r;
    logic        ld_r;
    logic [3:0]  num_r;
    logic        sext_r;
    logic        lwl_r;
    logic        lwr_r;
`ifdef MS_LWLR_EN
    logic [31:0] rt_r;
    logic [31:0] lwl_v;
    logic [31:0] lwr_v;
`endif
    logic        ms_valid;
    logic        resp_own;
    logic        ready_go;
    logic        allowin;
    logic        accept;
    logic        inc_wait;
    logic        inc_offer;
    logic        dec;
    logic [2:0]  cnt_next;
    logic [31:0] rd;
    logic [1:0]  off;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] aligned;
    logic [31:0] load_val;

    assign ms_valid  = state != EMPTY;
    // A response belongs to the WAIT instruction only once all discards are drained.
    assign resp_own  = data_data_ok && discard_cnt == 2'd0;
    assign ready_go  = state == READY || state == HELD || (state == WAIT && resp_own);
    assign allowin   = !ms_valid || (ready_go && ws_allowin);
    assign es.ms_allowin = allowin;
    assign accept    = es.es_to_ms_valid && allowin && !ws_reflush;
    // Flushed WAIT whose own response has not arrived yet leaves one response to drop.
    assign inc_wait  = ws_reflush && state == WAIT && !resp_own;
    // An issued request offered during a flush is refused but its response still comes.
    assign inc_offer = ws_reflush && es.es_to_ms_valid && es.es_mem_req;
    assign dec       = data_data_ok && discard_cnt != 2'd0;
    assign cnt_next  = {1'b0, discard_cnt} + {2'b0, inc_wait} + {2'b0, inc_offer} - {2'b0, dec};

    assign rd       = state == HELD ? buf_r : data_rdata;
    assign off      = num_r[0] ? 2'd0 : num_r[1] ? 2'd1 : num_r[2] ? 2'd2 : 2'd3;
    assign sel_b    = rd[{off, 3'b000} +: 8];
    assign sel_h    = rd[{off[1], 4'b0000} +: 16];
    assign aligned  = $countones(num_r) == 1 ? {{24{sext_r & sel_b[7]}}, sel_b} :
                      $countones(num_r) == 2 ? {{16{sext_r & sel_h[15]}}, sel_h} : rd;
`ifdef MS_LWLR_EN
    assign lwl_v    = num_r[3] ? rd :
                      num_r[2] ? {rd[23:0], rt_r[7:0]} :
                      num_r[1] ? {rd[15:0], rt_r[15:0]} : {rd[7:0], rt_r[23:0]};
    assign lwr_v    = num_r[0] ? rd :
                      num_r[1] ? {rt_r[31:24], rd[31:8]} :
                      num_r[2] ? {rt_r[31:16], rd[31:16]} : {rt_r[31:8], rd[31:24]};
    assign load_val = lwl_r ? lwl_v : lwr_r ? lwr_v : aligned;
`else
    assign load_val = (lwl_r || lwr_r) ? rd : aligned;
`endif

    assign ms_result       = (ld_r && (state == WAIT || state == HELD)) ? load_val : res_r;
    assign ms_to_ws_valid  = ms_valid && ready_go && !ws_reflush;
    assign ms_fwd_valid    = ms_valid && ms_gr_we;
    assign ms_load_pending = state == WAIT && !resp_own;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            discard_cnt <= 2'd0;
            ms_pc       <= 32'd0;
            res_r       <= 32'd0;
            buf_r       <= 32'd0;
            ms_dest     <= 5'd0;
            ms_gr_we    <= 1'b0;
            ld_r        <= 1'b0;
            num_r       <= 4'd0;
            sext_r      <= 1'b0;
            lwl_r       <= 1'b0;
            lwr_r       <= 1'b0;
`ifdef MS_LWLR_EN
            rt_r        <= 32'd0;
`endif
        end else begin
            discard_cnt <= cnt_next[1:0];
            if (ws_reflush) begin
                state <= EMPTY;
            end else if (accept) begin
                // Issued stores also wait here for their write response.
                state    <= es.es_mem_req ? WAIT : READY;
                ms_pc    <= es.es_pc;
                res_r    <= es.es_result;
                ms_dest  <= es.es_dest;
                ms_gr_we <= es.es_gr_we;
                ld_r     <= es.es_load;
                num_r    <= es.es_mem_num;
                sext_r   <= es.es_sign_ext;
                lwl_r    <= es.es_lwl;
                lwr_r    <= es.es_lwr;
`ifdef MS_LWLR_EN
                rt_r     <= es.es_rt_value;
`endif
            end else if (ready_go && ws_allowin) begin
                state <= EMPTY;
            end else if (state == WAIT && resp_own) begin
                state <= HELD;
                buf_r <= data_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (cnt_next <= 3'd3);
            assert (!(data_data_ok && discard_cnt == 2'd0 && state != WAIT));
        end
    end
endmodule
